// File: rtl/demux_3_seq_if.sv
// demux_3_seq_if -- bundle of the beat stream, the eight held lanes and the
// frame handshake of the 1-to-8 registered demultiplexer.
//
// Handshake semantics: a beat transfers on a rising clk edge where
// in_valid & in_ready are both high; in_ready depends only on the block's
// state, never on in_valid. A frame is held while frame_valid is high and is
// released on a rising edge where frame_valid & frame_ack are both high.
//
// Signals (master = producer/consumer side, slave = demux_3_seq):
//   ctrl0..ctrl2  lane select code {ctrl0,ctrl1,ctrl2}, ctrl0 = MSB
//   mode_auto     1 = internal sequencer picks lanes, 0 = ctrl addressing
//   in, in_valid  beat data and beat-present
//   in_ready      block accepts a beat this cycle
//   out0..out7    held lane registers
//   lane_vld      bit k = lane k written in current frame
//   frame_valid   all eight lanes written, frame held
//   frame_ack     consumer takes the frame
//   fsm_state     debug view of the frame FSM (0 IDLE, 1 FILL, 2 HOLD)
//   in_par        beat parity bit        (only with DEMUX3_PARITY_EN)
//   par_err       sticky parity error    (only with DEMUX3_PARITY_EN)
interface demux_3_seq_if #(
    parameter int WIDTH = 8
);
    logic             ctrl0;
    logic             ctrl1;
    logic             ctrl2;
    logic             mode_auto;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out5;
    logic [WIDTH-1:0] out6;
    logic [WIDTH-1:0] out7;
    logic [7:0]       lane_vld;
    logic             frame_valid;
    logic             frame_ack;
    logic [1:0]       fsm_state;
`ifdef DEMUX3_PARITY_EN
    logic             in_par;
    logic             par_err;
`endif

    modport master (
        output ctrl0, ctrl1, ctrl2, mode_auto, in, in_valid, frame_ack,
`ifdef DEMUX3_PARITY_EN
        output in_par,
        input  par_err,
`endif
        input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
        input  lane_vld, frame_valid, fsm_state
    );

    modport slave (
        input  ctrl0, ctrl1, ctrl2, mode_auto, in, in_valid, frame_ack,
`ifdef DEMUX3_PARITY_EN
        input  in_par,
        output par_err,
`endif
        output in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
        output lane_vld, frame_valid, fsm_state
    );
endinterface

// File: rtl/demux_3_seq.sv
// demux_3_seq -- registered 1-to-8 demultiplexer / frame collector.
// Each accepted beat is steered into one of eight held lanes, chosen by the
// ctrl code (direct mode) or by an internal sequencer (auto mode). The mode
// is latched by the first beat of a frame. When all eight lanes hold data
// the frame is presented (frame_valid) and frozen until frame_ack.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    demux_3_seq_if.slave (beat stream, lanes, frame handshake)
//
// Optional feature macro: DEMUX3_PARITY_EN -- even-parity check per beat;
// beats failing parity are consumed but dropped and set the sticky par_err.
module demux_3_seq #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    demux_3_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       seq_q;
    logic             mode_q;
    logic [WIDTH-1:0] lane_q [8];
    logic [7:0]       vld_q;
    logic             fv_q;

    logic             accept;
    logic             beat_ok;
    logic             par_ok;
    logic             mode_eff;
    logic [2:0]       idx;
    logic [7:0]       vld_set;
    logic             hold_exit;

    assign bus.in_ready = (state_q != HOLD);
    assign accept       = bus.in_valid & bus.in_ready;

`ifdef DEMUX3_PARITY_EN
    logic par_err_q;
    assign par_ok      = ~^{bus.in, bus.in_par};
    assign bus.par_err = par_err_q;
`else
    assign par_ok = 1'b1;
`endif

    // Only beats that pass parity (always, without the feature) touch lanes.
    assign beat_ok   = accept & par_ok;
    assign hold_exit = (state_q == HOLD) & bus.frame_ack;

    // The first beat of a frame uses the live mode_auto, which it also latches.
    assign mode_eff = (state_q == IDLE) ? bus.mode_auto : mode_q;
    assign idx      = mode_eff ? seq_q : {bus.ctrl0, bus.ctrl1, bus.ctrl2};
    assign vld_set  = vld_q | (8'b1 << idx);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beat_ok) state_d = FILL;
            FILL:    if (beat_ok && vld_set == 8'hFF) state_d = HOLD;
            HOLD:    if (bus.frame_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seq_q   <= 3'd0;
            mode_q  <= 1'b0;
            vld_q   <= 8'h00;
            fv_q    <= 1'b0;
            for (int k = 0; k < 8; k++) lane_q[k] <= '0;
        end else begin
            state_q <= state_d;
            fv_q    <= (state_d == HOLD);
            if (hold_exit) begin
                // Lane data stays visible; only the frame bookkeeping clears.
                vld_q <= 8'h00;
                seq_q <= 3'd0;
            end else if (beat_ok) begin
                lane_q[idx] <= bus.in;
                vld_q       <= vld_set;
                if (mode_eff) seq_q <= seq_q + 3'd1;
                if (state_q == IDLE) mode_q <= bus.mode_auto;
            end
        end
    end

`ifdef DEMUX3_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (hold_exit) begin
            par_err_q <= 1'b0;
        end else if (accept && !par_ok) begin
            par_err_q <= 1'b1;
        end
    end
`endif

    assign bus.out0        = lane_q[0];
    assign bus.out1        = lane_q[1];
    assign bus.out2        = lane_q[2];
    assign bus.out3        = lane_q[3];
    assign bus.out4        = lane_q[4];
    assign bus.out5        = lane_q[5];
    assign bus.out6        = lane_q[6];
    assign bus.out7        = lane_q[7];
    assign bus.lane_vld    = vld_q;
    assign bus.frame_valid = fv_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_demux_3_seq.sv
// tb_demux_3_seq -- directed bench for demux_3_seq with hand-computed
// expected values. Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, so they reflect the edge just taken.
module tb_demux_3_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux_3_seq_if #(.WIDTH(W)) bus ();

    demux_3_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] code, input logic [W-1:0] d);
        {bus.ctrl0, bus.ctrl1, bus.ctrl2} = code;
        bus.in       = d;
`ifdef DEMUX3_PARITY_EN
        bus.in_par   = ^d;
`endif
        bus.in_valid = 1'b1;
    endtask

    task automatic beat(input logic [2:0] code, input logic [W-1:0] d);
        drive(code, d);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic ack_frame();
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ctrl0 = 1'b0; bus.ctrl1 = 1'b0; bus.ctrl2 = 1'b0;
        bus.mode_auto = 1'b0;
        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b0;
`ifdef DEMUX3_PARITY_EN
        bus.in_par    = 1'b0;
`endif
        step();
        step();

        // reset state
        chk("rst_out0", bus.out0, 8'h00);
        chk("rst_out7", bus.out7, 8'h00);
        chk("rst_lane_vld", bus.lane_vld, 8'h00);
        chk("rst_frame_valid", bus.frame_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_state", bus.fsm_state, 2'd0);
        rst_n = 1'b1;
        step();

        // auto mode: 10..17 on consecutive cycles
        bus.mode_auto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'd5, 8'h10 + W'(i));
            step();
            if (i == 6) begin
                chk("auto_ready_b7", bus.in_ready, 1'b1);
                chk("auto_vld_b7", bus.lane_vld, 8'h7F);
                chk("auto_fv_b7", bus.frame_valid, 1'b0);
            end
        end
        chk("auto_fv", bus.frame_valid, 1'b1);
        chk("auto_ready_low", bus.in_ready, 1'b0);
        chk("auto_vld", bus.lane_vld, 8'hFF);
        chk("auto_out0", bus.out0, 8'h10);
        chk("auto_out3", bus.out3, 8'h13);
        chk("auto_out5", bus.out5, 8'h15);
        chk("auto_out7", bus.out7, 8'h17);

        // HOLD with a pending beat and no ack
        drive(3'd0, 8'hAA);
        for (int i = 0; i < 5; i++) step();
        chk("hold_out0", bus.out0, 8'h10);
        chk("hold_out7", bus.out7, 8'h17);
        chk("hold_ready", bus.in_ready, 1'b0);
        chk("hold_fv", bus.frame_valid, 1'b1);
        chk("hold_state", bus.fsm_state, 2'd2);

        // ack with in_valid still high: beat not taken on this edge
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        chk("ack_vld", bus.lane_vld, 8'h00);
        chk("ack_fv", bus.frame_valid, 1'b0);
        chk("ack_ready", bus.in_ready, 1'b1);
        chk("ack_out0_kept", bus.out0, 8'h10);
        step();
        bus.in_valid = 1'b0;
        chk("aa_out0", bus.out0, 8'hAA);
        chk("aa_vld", bus.lane_vld, 8'h01);
        chk("aa_out1_kept", bus.out1, 8'h11);

        // three more auto beats, then a mid-frame reset
        beat(3'd0, 8'hAB);
        beat(3'd0, 8'hAC);
        beat(3'd0, 8'hAD);
        chk("pre_rst_vld", bus.lane_vld, 8'h0F);
        chk("pre_rst_out3", bus.out3, 8'hAD);
        rst_n = 1'b0;
        #1;
        chk("arst_out0", bus.out0, 8'h00);
        chk("arst_out3", bus.out3, 8'h00);
        chk("arst_vld", bus.lane_vld, 8'h00);
        chk("arst_ready", bus.in_ready, 1'b1);
        drive(3'd0, 8'hEE);
        step();
        bus.in_valid = 1'b0;
        chk("rst_no_accept", bus.out0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) beat(3'd2, 8'h20 + W'(i));
        chk("post_rst_out0", bus.out0, 8'h20);
        chk("post_rst_out2", bus.out2, 8'h22);
        chk("post_rst_out7", bus.out7, 8'h27);
        chk("post_rst_fv", bus.frame_valid, 1'b1);
        ack_frame();

        // direct mode, including a rewrite of lane 3
        bus.mode_auto = 1'b0;
        beat(3'd7, 8'h70);
        beat(3'd3, 8'h31);
        chk("dir_vld_88", bus.lane_vld, 8'h88);
        beat(3'd3, 8'h32);
        chk("dir_rewrite_vld", bus.lane_vld, 8'h88);
        chk("dir_rewrite_out3", bus.out3, 8'h32);
        beat(3'd0, 8'h00);
        beat(3'd1, 8'h11);
        beat(3'd2, 8'h22);
        beat(3'd4, 8'h44);
        beat(3'd5, 8'h55);
        chk("dir_vld_bf", bus.lane_vld, 8'hBF);
        chk("dir_fv_early", bus.frame_valid, 1'b0);
        chk("dir_ready_early", bus.in_ready, 1'b1);
        beat(3'd6, 8'h66);
        chk("dir_fv", bus.frame_valid, 1'b1);
        chk("dir_out3", bus.out3, 8'h32);
        chk("dir_out6", bus.out6, 8'h66);
        chk("dir_out7", bus.out7, 8'h70);
        chk("dir_out0", bus.out0, 8'h00);
        // ack without HOLD is ignored later; here it releases the frame
        ack_frame();

        // ack outside HOLD has no effect on a partial frame
        beat(3'd0, 8'hA0);
        ack_frame();
        chk("ack_idle_vld", bus.lane_vld, 8'h01);
        chk("ack_idle_state", bus.fsm_state, 2'd1);

        // mode switch mid-frame: remaining beats keep ctrl addressing
        beat(3'd1, 8'hA1);
        beat(3'd2, 8'hA2);
        bus.mode_auto = 1'b1;
        beat(3'd7, 8'hB7);
        beat(3'd6, 8'hB6);
        beat(3'd5, 8'hB5);
        beat(3'd4, 8'hB4);
        beat(3'd3, 8'hB3);
        chk("sw_fv", bus.frame_valid, 1'b1);
        chk("sw_out0", bus.out0, 8'hA0);
        chk("sw_out3", bus.out3, 8'hB3);
        chk("sw_out7", bus.out7, 8'hB7);
        ack_frame();

        // next frame runs in auto mode; ctrl points elsewhere
        beat(3'd5, 8'hC0);
        chk("auto2_out0", bus.out0, 8'hC0);
        chk("auto2_out5", bus.out5, 8'hB5);
        chk("auto2_vld", bus.lane_vld, 8'h01);

`ifdef DEMUX3_PARITY_EN
        drive(3'd5, 8'h01);
        bus.in_par = 1'b0;
        step();
        bus.in_valid = 1'b0;
        chk("par_drop_err", bus.par_err, 1'b1);
        chk("par_drop_vld", bus.lane_vld, 8'h01);
        chk("par_drop_out1", bus.out1, 8'hA1);
        drive(3'd5, 8'h01);
        bus.in_par = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("par_ok_out1", bus.out1, 8'h01);
        chk("par_ok_vld", bus.lane_vld, 8'h03);
        chk("par_err_sticky", bus.par_err, 1'b1);
`endif

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
